tape_lcd_printer: RTL and testbench



---
 rtl/tape_lcd_printer_pkg.sv | 45 ++++
 rtl/tape_lcd_printer_if.sv | 31 +++
 rtl/tape_lcd_printer_lcd_write_engine.sv | 100 ++++++++++
 rtl/tape_lcd_printer.sv | 117 +++++++++++
 tb/tb_tape_lcd_printer.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/tape_lcd_printer_pkg.sv
// tape_pkg: shared definitions for the tape LCD printer.
//   - Tape symbol codes and the symbol -> ASCII map.
//   - HD44780 command bytes and the power-up init command order.
//   - State encodings for the printer FSM and the LCD write engine.
package tape_pkg;

    localparam logic [1:0] SYM_BLANK = 2'b00;
    localparam logic [1:0] SYM_ZERO  = 2'b01;
    localparam logic [1:0] SYM_ONE   = 2'b10;
    localparam logic [1:0] SYM_HASH  = 2'b11;

    localparam logic [7:0] CMD_FUNC_SET = 8'h38;
    localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
    localparam logic [7:0] CMD_CLEAR    = 8'h01;
    localparam logic [7:0] CMD_ENTRY    = 8'h06;
    localparam logic [7:0] CMD_LINE1    = 8'h80;

    typedef enum logic [3:0] {
        S_PWRUP, S_INIT, S_INIT_W, S_IDLE, S_SETADDR, S_SETADDR_W,
        S_REQ, S_CAPT, S_CHAR, S_CHAR_W, S_DONE, S_WAITLOW
    } prn_state_t;

    typedef enum logic [2:0] {
        E_PWRUP, E_IDLE, E_SETUP, E_EN, E_HOLD, E_WAIT
    } eng_state_t;

    function automatic logic [7:0] sym_to_ascii(input logic [1:0] sym);
        case (sym)
            SYM_BLANK: return 8'h5F;
            SYM_ZERO:  return 8'h30;
            SYM_ONE:   return 8'h31;
            default:   return 8'h23;
        endcase
    endfunction

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    return CMD_FUNC_SET;
            2'd1:    return CMD_DISP_ON;
            2'd2:    return CMD_CLEAR;
            default: return CMD_ENTRY;
        endcase
    endfunction

endpackage

// File: rtl/tape_lcd_printer_if.sv
// tape_lcd_printer_if: print handshake, tape read port and LCD bus.
//   slave  : the printer (drives print_done/ready, tape strobe/address, LCD pins)
//   master : the machine / environment (drives print_start, window_base, mem_data)
interface tape_lcd_printer_if #(
    parameter int ADDR_W = 11
) ();
    logic              print_start;
    logic              print_done;
    logic [ADDR_W-1:0] window_base;
    logic              ready;
    logic              mem_access;
    logic              mem_rw;
    logic [ADDR_W-1:0] mem_addr;
    logic [1:0]        mem_data;
    logic [7:0]        lcd_data;
    logic              lcd_rs;
    logic              lcd_rw;
    logic              lcd_en;

    modport slave (
        input  print_start, window_base, mem_data,
        output print_done, ready, mem_access, mem_rw, mem_addr,
               lcd_data, lcd_rs, lcd_rw, lcd_en
    );

    modport master (
        output print_start, window_base, mem_data,
        input  print_done, ready, mem_access, mem_rw, mem_addr,
               lcd_data, lcd_rs, lcd_rw, lcd_en
    );
endinterface

// File: rtl/tape_lcd_printer_lcd_write_engine.sv
// lcd_write_engine: owns the LCD pins and the shared wait counter.
//   Out of reset it counts PWRUP_WAIT clocks and pulses done.
//   Afterwards each req (accepted only when idle) performs one write:
//   setup 1 clk, lcd_en high EN_CYCLES, hold 1 clk, then CMD_WAIT
//   (or CLR_WAIT when long_wait) idle clocks; done pulses in the last
//   wait clock.
// Ports: clk, rst, req, rs, data[7:0], long_wait -> done, lcd_data, lcd_rs,
//   lcd_rw, lcd_en.
module lcd_write_engine
    import tape_pkg::*;
#(
    parameter int EN_CYCLES  = 12,
    parameter int CMD_WAIT   = 2500,
    parameter int CLR_WAIT   = 100000,
    parameter int PWRUP_WAIT = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic       rs,
    input  logic [7:0] data,
    input  logic       long_wait,
    output logic       done,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en
);
    localparam int M1 = (PWRUP_WAIT > CLR_WAIT) ? PWRUP_WAIT : CLR_WAIT;
    localparam int M2 = (M1 > CMD_WAIT) ? M1 : CMD_WAIT;
    localparam int M3 = (M2 > EN_CYCLES) ? M2 : EN_CYCLES;
    localparam int CW = $clog2(M3 + 1);

    eng_state_t    r_state, w_next;
    logic [CW-1:0] r_cnt, w_cnt_next, w_wait_last;
    logic [7:0]    r_data;
    logic          r_rs;
    logic          r_long;

    assign w_wait_last = r_long ? CW'(CLR_WAIT - 1) : CW'(CMD_WAIT - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= E_PWRUP;
            r_cnt   <= '0;
            r_data  <= '0;
            r_rs    <= 1'b0;
            r_long  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            if (r_state == E_IDLE && req) begin
                r_data <= data;
                r_rs   <= rs;
                r_long <= long_wait;
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt + CW'(1);
        done       = 1'b0;
        case (r_state)
            E_PWRUP: if (r_cnt == CW'(PWRUP_WAIT - 1)) begin
                done       = 1'b1;
                w_next     = E_IDLE;
                w_cnt_next = '0;
            end
            E_IDLE: begin
                w_cnt_next = '0;
                if (req) w_next = E_SETUP;
            end
            E_SETUP: begin
                w_next     = E_EN;
                w_cnt_next = '0;
            end
            E_EN: if (r_cnt == CW'(EN_CYCLES - 1)) begin
                w_next     = E_HOLD;
                w_cnt_next = '0;
            end
            E_HOLD: begin
                w_next     = E_WAIT;
                w_cnt_next = '0;
            end
            E_WAIT: if (r_cnt == w_wait_last) begin
                done       = 1'b1;
                w_next     = E_IDLE;
                w_cnt_next = '0;
            end
            default: w_next = E_PWRUP;
        endcase
    end

    assign lcd_data = r_data;
    assign lcd_rs   = r_rs;
    assign lcd_rw   = 1'b0;
    assign lcd_en   = (r_state == E_EN);

endmodule

// File: rtl/tape_lcd_printer.sv
// tape_lcd_printer: on print_start, reads WINDOW tape cells from
// window_base (wrapping modulo 2^ADDR_W), renders them on LCD line 1 and
// pulses print_done; runs the LCD power-up init after reset.
// Ports: clk, rst (sync, active-high), bus (tape_lcd_printer_if.slave):
//   print_start/print_done/ready handshake, window_base, tape read port
//   (mem_access, mem_rw, mem_addr, mem_data) and LCD pins.
module tape_lcd_printer
    import tape_pkg::*;
#(
    parameter int WINDOW     = 16,
    parameter int ADDR_W     = 11,
    parameter int EN_CYCLES  = 12,
    parameter int CMD_WAIT   = 2500,
    parameter int CLR_WAIT   = 100000,
    parameter int PWRUP_WAIT = 1000000
) (
    input  logic clk,
    input  logic rst,
    tape_lcd_printer_if.slave bus
);
    localparam logic [3:0] LAST_IDX = 4'(WINDOW - 1);

    prn_state_t        r_state, w_next;
    logic [ADDR_W-1:0] r_base;
    logic [3:0]        r_idx;
    logic [1:0]        r_init_idx;
    logic [1:0]        r_sym;
    logic              w_req, w_rs, w_long, w_eng_done;
    logic [7:0]        w_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_PWRUP;
            r_base     <= '0;
            r_idx      <= '0;
            r_init_idx <= '0;
            r_sym      <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: if (bus.print_start) begin
                    r_base <= bus.window_base;
                    r_idx  <= '0;
                end
                S_INIT_W: if (w_eng_done) r_init_idx <= r_init_idx + 2'd1;
                S_CAPT:   r_sym <= bus.mem_data;
                S_CHAR_W: if (w_eng_done && r_idx != LAST_IDX) r_idx <= r_idx + 4'd1;
                default: ;
            endcase
        end
    end

    // Each command/char state raises req for one cycle only; the matching
    // _W state then waits for the engine, which is idle again on the cycle
    // after its done pulse.
    always_comb begin
        w_next = r_state;
        w_req  = 1'b0;
        w_rs   = 1'b0;
        w_long = 1'b0;
        w_data = init_cmd(r_init_idx);
        case (r_state)
            S_PWRUP: if (w_eng_done) w_next = S_INIT;
            S_INIT: begin
                w_req  = 1'b1;
                w_long = (init_cmd(r_init_idx) == CMD_CLEAR);
                w_next = S_INIT_W;
            end
            S_INIT_W: if (w_eng_done) w_next = (r_init_idx == 2'd3) ? S_IDLE : S_INIT;
            S_IDLE: if (bus.print_start) w_next = S_SETADDR;
            S_SETADDR: begin
                w_req  = 1'b1;
                w_data = CMD_LINE1;
                w_next = S_SETADDR_W;
            end
            S_SETADDR_W: if (w_eng_done) w_next = S_REQ;
            S_REQ:  w_next = S_CAPT;
            S_CAPT: w_next = S_CHAR;
            S_CHAR: begin
                w_req  = 1'b1;
                w_rs   = 1'b1;
                w_data = sym_to_ascii(r_sym);
                w_next = S_CHAR_W;
            end
            S_CHAR_W: if (w_eng_done) w_next = (r_idx == LAST_IDX) ? S_DONE : S_REQ;
            S_DONE:    w_next = S_WAITLOW;
            S_WAITLOW: if (!bus.print_start) w_next = S_IDLE;
            default:   w_next = S_PWRUP;
        endcase
    end

    lcd_write_engine #(
        .EN_CYCLES (EN_CYCLES),
        .CMD_WAIT  (CMD_WAIT),
        .CLR_WAIT  (CLR_WAIT),
        .PWRUP_WAIT(PWRUP_WAIT)
    ) u_eng (
        .clk      (clk),
        .rst      (rst),
        .req      (w_req),
        .rs       (w_rs),
        .data     (w_data),
        .long_wait(w_long),
        .done     (w_eng_done),
        .lcd_data (bus.lcd_data),
        .lcd_rs   (bus.lcd_rs),
        .lcd_rw   (bus.lcd_rw),
        .lcd_en   (bus.lcd_en)
    );

    assign bus.print_done = (r_state == S_DONE);
    assign bus.ready      = (r_state == S_IDLE);
    assign bus.mem_access = (r_state == S_REQ);
    assign bus.mem_rw     = 1'b1;
    assign bus.mem_addr   = r_base + ADDR_W'(r_idx);

endmodule

// File: tb/tb_tape_lcd_printer.sv
// Bench for tape_lcd_printer with small timing parameters. Expected LCD
// writes and tape addresses are queued when stimulus is applied and
// popped by a monitor when the DUT produces them.
module tb_tape_lcd_printer;
    localparam int EN_CYCLES = 2;
    localparam int CMD_WAIT  = 4;
    localparam int CLR_WAIT  = 8;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         gap;   // expected en-low cycles before this write, -1 = unchecked
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0] r_mdata = 2'b00;
    logic [1:0] tape [0:2047];
    logic [7:0] amap [0:3];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_done = 0, n_acc = 0, n_chars = 0, n_rise = 0, last_rise_cyc = 0;
    int hi_cnt = 0, lo_cnt = -1, done_run = 0;
    logic prev_en = 1'b0;

    wr_t        exp_wr[$];
    logic [10:0] exp_addr[$];

    tape_lcd_printer_if #(.ADDR_W(11)) bus ();

    tape_lcd_printer #(
        .WINDOW    (4),
        .ADDR_W    (11),
        .EN_CYCLES (EN_CYCLES),
        .CMD_WAIT  (CMD_WAIT),
        .CLR_WAIT  (CLR_WAIT),
        .PWRUP_WAIT(10)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Tape model: data for the strobed address is valid the next cycle.
    always @(posedge clk) if (bus.mem_access) r_mdata <= tape[bus.mem_addr];
    assign bus.mem_data = r_mdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_wr(input logic rs, input logic [7:0] d, input int gap);
        wr_t e;
        e.rs = rs; e.data = d; e.gap = gap;
        exp_wr.push_back(e);
    endtask

    // Init gaps: hold 1 + wait + issue 1 + setup 1.
    task automatic push_init();
        push_wr(1'b0, 8'h38, -1);
        push_wr(1'b0, 8'h0C, CMD_WAIT + 3);
        push_wr(1'b0, 8'h01, CMD_WAIT + 3);
        push_wr(1'b0, 8'h06, CLR_WAIT + 3);
    endtask

    // Char gaps: hold 1 + wait + REQ + CAPT + CHAR + setup 1.
    task automatic push_pass(input logic [10:0] base);
        logic [10:0] a;
        push_wr(1'b0, 8'h80, -1);
        for (int i = 0; i < 4; i++) begin
            a = base + 11'(i);
            exp_addr.push_back(a);
            push_wr(1'b1, amap[tape[a]], CMD_WAIT + 5);
        end
    endtask

    task automatic check_reset_vals();
        check("rst_done",   32'(bus.print_done), 0);
        check("rst_access", 32'(bus.mem_access), 0);
        check("rst_en",     32'(bus.lcd_en), 0);
        check("rst_rs",     32'(bus.lcd_rs), 0);
        check("rst_rw",     32'(bus.lcd_rw), 0);
        check("rst_ready",  32'(bus.ready), 0);
        check("rst_data",   32'(bus.lcd_data), 0);
        check("rst_addr",   32'(bus.mem_addr), 0);
        check("rst_mem_rw", 32'(bus.mem_rw), 1);
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!bus.ready && n < 400) begin @(negedge clk); n++; end
        check(tag, 32'(bus.ready), 1);
    endtask

    task automatic wait_done(input int target, input string tag);
        int n = 0;
        while (n_done < target && n < 400) begin @(negedge clk); n++; end
        check(tag, 32'(n_done), 32'(target));
    endtask

    // Monitor: LCD writes, tape strobes and print_done pulses.
    always @(negedge clk) begin
        if (rst) begin
            prev_en  = 1'b0;
            hi_cnt   = 0;
            lo_cnt   = -1;
            done_run = 0;
        end else begin
            if (bus.lcd_en && !prev_en) begin
                if (exp_wr.size() == 0) begin
                    check("lcd_extra", 32'(exp_wr.size()), 1);
                end else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    check("lcd_rs", 32'(bus.lcd_rs), 32'(e.rs));
                    check("lcd_data", 32'(bus.lcd_data), 32'(e.data));
                    if (e.gap >= 0 && lo_cnt >= 0) check("lcd_gap", 32'(lo_cnt), 32'(e.gap));
                end
                if (bus.lcd_rs) n_chars++;
                n_rise++;
                last_rise_cyc = cyc;
                hi_cnt = 1;
            end else if (bus.lcd_en) begin
                hi_cnt++;
            end else if (prev_en) begin
                check("en_width", 32'(hi_cnt), 32'(EN_CYCLES));
                lo_cnt = 1;
            end else if (lo_cnt >= 0) begin
                lo_cnt++;
            end
            prev_en = bus.lcd_en;

            if (bus.mem_access) begin
                n_acc++;
                if (exp_addr.size() == 0) check("mem_extra", 32'(exp_addr.size()), 1);
                else check("mem_addr", 32'(bus.mem_addr), 32'(exp_addr.pop_front()));
            end

            if (bus.print_done) begin
                if (done_run == 0) n_done++;
                done_run++;
            end else if (done_run != 0) begin
                check("done_width", 32'(done_run), 1);
                done_run = 0;
            end
        end
    end

    initial begin
        int acc0, dn, r0, c0, ch0, n;
        amap[0] = 8'h5F; amap[1] = 8'h30; amap[2] = 8'h31; amap[3] = 8'h23;
        for (int i = 0; i < 2048; i++) tape[i] = 2'b00;
        tape[11'h200] = 2'b01; tape[11'h201] = 2'b10;
        tape[11'h202] = 2'b11; tape[11'h203] = 2'b00;
        tape[11'h7FE] = 2'b11; tape[11'h7FF] = 2'b00;
        tape[11'h000] = 2'b01; tape[11'h001] = 2'b10;
        bus.print_start = 1'b0;
        bus.window_base = '0;

        // Reset and power-up init
        repeat (3) @(negedge clk);
        check_reset_vals();
        push_init();
        rst = 1'b0;
        @(negedge clk);
        check("pwrup_ready", 32'(bus.ready), 0);
        wait_ready("tmo_init");
        check("init_drain", 32'(exp_wr.size()), 0);

        // First pass; base change mid-pass must be ignored
        bus.window_base = 11'h200;
        push_pass(11'h200);
        bus.print_start = 1'b1;
        repeat (5) @(negedge clk);
        bus.window_base = 11'h123;
        wait_done(1, "tmo_pass1");
        acc0 = n_acc;
        repeat (50) @(negedge clk);
        check("hold_no_reread", 32'(n_acc), 32'(acc0));
        check("hold_not_ready", 32'(bus.ready), 0);
        check("hold_one_done", 32'(n_done), 1);
        bus.print_start = 1'b0;
        wait_ready("tmo_lowered");
        check("pass1_drain", 32'(exp_wr.size() + exp_addr.size()), 0);

        // Re-raise: a new full pass
        bus.window_base = 11'h200;
        push_pass(11'h200);
        bus.print_start = 1'b1;
        wait_done(2, "tmo_pass2");
        bus.print_start = 1'b0;
        wait_ready("tmo_ready2");
        check("pass2_drain", 32'(exp_wr.size() + exp_addr.size()), 0);

        // Address wrap at the top of the tape
        bus.window_base = 11'h7FE;
        push_pass(11'h7FE);
        bus.print_start = 1'b1;
        wait_done(3, "tmo_wrap");
        bus.print_start = 1'b0;
        wait_ready("tmo_ready3");
        check("wrap_drain", 32'(exp_wr.size() + exp_addr.size()), 0);

        // Reset after two chars, request kept high through power-up
        bus.window_base = 11'h200;
        push_pass(11'h200);
        ch0 = n_chars;
        bus.print_start = 1'b1;
        n = 0;
        while (n_chars < ch0 + 2 && n < 400) begin @(negedge clk); n++; end
        check("mid_two_chars", 32'(n_chars), 32'(ch0 + 2));
        repeat (3) @(negedge clk);
        dn = n_done;
        rst = 1'b1;
        @(negedge clk);
        check_reset_vals();
        exp_wr.delete();
        exp_addr.delete();
        push_init();
        push_pass(11'h200);
        @(negedge clk);
        rst = 1'b0;
        wait_ready("tmo_reinit");
        check("abort_no_done", 32'(n_done), 32'(dn));
        c0 = cyc;
        r0 = n_rise;
        n = 0;
        while (n_rise == r0 && n < 20) begin @(negedge clk); n++; end
        // ready cycle, IDLE sampling edge, then lcd_en rises 2 edges later
        check("start_latency", 32'(last_rise_cyc - c0), 3);
        wait_done(dn + 1, "tmo_pass_after_rst");
        bus.print_start = 1'b0;
        wait_ready("tmo_ready4");
        check("rst_pass_drain", 32'(exp_wr.size() + exp_addr.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
